// File: rtl/pocket_pad_encoder.sv
// -----------------------------------------------------------------------------
// pocket_pad_encoder
//
// Builds Analogue Pocket controller words (cont_key / cont_joy) from discrete
// button and direction state. On an accepted frame strobe it samples the
// buttons and the left-stick direction, SOCD-cleans both, moves the synthetic
// left-stick analog values toward their targets and offers the word pair to a
// consumer through a valid/ready handshake.
//
// Configuration macro: POCKET_PAD_SLEW_EN
//   defined   - lx/ly ramp toward their target by SLEW_STEP per accepted strobe
//   undefined - lx/ly load their target directly (SLEW_STEP unused)
//
// Parameters:
//   PAD_TYPE    - value placed in cont_key[31:29]
//   SLEW_STEP   - per-strobe analog step, legal range 1..8'h80
//
// Ports:
//   clk_sys      in   1  system clock, rising edge
//   reset_n      in   1  asynchronous active-low reset
//   frame_stb    in   1  one-cycle sample request
//   key_in       in  16  button bitmap ([0] up, [1] down, [2] left, [3] right ...)
//   stick_dir    in   4  left-stick request {right, left, down, up}
//   word_ready   in   1  consumer accepts the current words
//   word_valid   out  1  words hold an unconsumed sample
//   cont_key     out 32  {PAD_TYPE, 13'h0, key[15:0]}
//   cont_joy     out 32  {ry, rx, ly, lx}
//   overrun_cnt  out  8  saturating count of dropped strobes
// -----------------------------------------------------------------------------
module pocket_pad_encoder #(
  parameter logic [2:0] PAD_TYPE  = 3'd1,
  parameter logic [7:0] SLEW_STEP = 8'h20
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        frame_stb,
  input  logic [15:0] key_in,
  input  logic [3:0]  stick_dir,
  input  logic        word_ready,
  output logic        word_valid,
  output logic [31:0] cont_key,
  output logic [31:0] cont_joy,
  output logic [7:0]  overrun_cnt
);

  localparam logic [7:0] STICK_MIN = 8'h00;
  localparam logic [7:0] STICK_MID = 8'h80;
  localparam logic [7:0] STICK_MAX = 8'hFF;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } state_e;

  // Elaboration-time guard on the slew step range.
  if ((SLEW_STEP == 8'h00) || (SLEW_STEP > 8'h80)) begin : g_bad_slew_step
    $error("pocket_pad_encoder: SLEW_STEP must be in 1..8'h80");
  end

  // Opposing directions cancel: bit layout {right, left, down, up} is shared by
  // the low nibble of key_in and by stick_dir.
  function automatic logic [3:0] socd_clean(input logic [3:0] dir);
    logic [3:0] res;
    res[1:0] = (dir[1:0] == 2'b11) ? 2'b00 : dir[1:0];
    res[3:2] = (dir[3:2] == 2'b11) ? 2'b00 : dir[3:2];
    return res;
  endfunction

  // Analog target for one axis from its cleaned negative/positive requests.
  function automatic logic [7:0] axis_target(input logic neg, input logic pos);
    logic [7:0] res;
    if (neg) begin
      res = STICK_MIN;
    end else if (pos) begin
      res = STICK_MAX;
    end else begin
      res = STICK_MID;
    end
    return res;
  endfunction

`ifdef POCKET_PAD_SLEW_EN
  // One slew step toward tgt, clamped at tgt. 9-bit math keeps the sums from
  // wrapping near 8'h00 / 8'hFF.
  function automatic logic [7:0] slew_toward(input logic [7:0] cur, input logic [7:0] tgt);
    logic [8:0] up_sum;
    logic [8:0] dn_lim;
    logic [7:0] res;
    up_sum = {1'b0, cur} + {1'b0, SLEW_STEP};
    dn_lim = {1'b0, tgt} + {1'b0, SLEW_STEP};
    if (cur < tgt) begin
      res = (up_sum > {1'b0, tgt}) ? tgt : up_sum[7:0];
    end else if (cur > tgt) begin
      res = ({1'b0, cur} < dn_lim) ? tgt : (cur - SLEW_STEP);
    end else begin
      res = cur;
    end
    return res;
  endfunction
`endif

  state_e      state_q, state_d;
  logic [15:0] key_q, key_d;
  logic [7:0]  lx_q, lx_d;
  logic [7:0]  ly_q, ly_d;
  logic [7:0]  overrun_q, overrun_d;

  logic        load_s;
  logic [3:0]  dir_clean_s;
  logic [7:0]  lx_tgt_s;
  logic [7:0]  ly_tgt_s;

  // Handshake state machine, strobe acceptance and word construction.
  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    lx_d        = lx_q;
    ly_d        = ly_q;
    overrun_d   = overrun_q;
    load_s      = 1'b0;
    dir_clean_s = socd_clean(stick_dir);
    lx_tgt_s    = axis_target(dir_clean_s[2], dir_clean_s[3]);
    ly_tgt_s    = axis_target(dir_clean_s[0], dir_clean_s[1]);

    case (state_q)
      ST_IDLE: begin
        // word_ready is ignored while nothing is pending.
        if (frame_stb) begin
          load_s  = 1'b1;
          state_d = ST_PEND;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PEND: begin
        if (frame_stb && word_ready) begin
          // Handshake and new sample in the same cycle: not an overrun.
          load_s  = 1'b1;
          state_d = ST_PEND;
        end else if (frame_stb) begin
          // Strobe lands on an unconsumed word: drop it and count it.
          state_d   = ST_PEND;
          overrun_d = (overrun_q == 8'hFF) ? overrun_q : (overrun_q + 8'd1);
        end else if (word_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_PEND;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (load_s) begin
      key_d = {key_in[15:4], socd_clean(key_in[3:0])};
`ifdef POCKET_PAD_SLEW_EN
      lx_d  = slew_toward(lx_q, lx_tgt_s);
      ly_d  = slew_toward(ly_q, ly_tgt_s);
`else
      lx_d  = lx_tgt_s;
      ly_d  = ly_tgt_s;
`endif
    end else begin
      key_d = key_q;
      lx_d  = lx_q;
      ly_d  = ly_q;
    end
  end

  // State and word registers; reset returns to centred sticks, no keys.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      key_q     <= 16'h0000;
      lx_q      <= STICK_MID;
      ly_q      <= STICK_MID;
      overrun_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      key_q     <= key_d;
      lx_q      <= lx_d;
      ly_q      <= ly_d;
      overrun_q <= overrun_d;
    end
  end

  assign word_valid  = (state_q == ST_PEND);
  assign cont_key    = {PAD_TYPE, 13'h0000, key_q};
  assign cont_joy    = {STICK_MID, STICK_MID, ly_q, lx_q};
  assign overrun_cnt = overrun_q;

endmodule

// File: tb/tb_pocket_pad_encoder.sv
// -----------------------------------------------------------------------------
// tb_pocket_pad_encoder
//
// Self-checking bench for pocket_pad_encoder. A behavioural model tracks the
// pending flag, the cleaned key bitmap, the stick values and the overrun count
// as plain integers; a compare process checks every DUT output against it on
// each falling edge. Directed phases pin the model with literal expectations,
// then a randomized phase (with occasional asynchronous resets) exercises the
// handshake. Honours POCKET_PAD_SLEW_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_pocket_pad_encoder;

  localparam logic [2:0] PAD   = 3'd1;
  localparam logic [7:0] SSTEP = 8'h20;
`ifdef POCKET_PAD_SLEW_EN
  localparam int SLEW = 32;
`endif

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        frame_stb = 1'b0;
  logic [15:0] key_in = 16'h0000;
  logic [3:0]  stick_dir = 4'h0;
  logic        word_ready = 1'b0;
  logic        word_valid;
  logic [31:0] cont_key;
  logic [31:0] cont_joy;
  logic [7:0]  overrun_cnt;

  int n_checks = 0;
  int n_errors = 0;

  pocket_pad_encoder #(
    .PAD_TYPE (PAD),
    .SLEW_STEP(SSTEP)
  ) dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .frame_stb  (frame_stb),
    .key_in     (key_in),
    .stick_dir  (stick_dir),
    .word_ready (word_ready),
    .word_valid (word_valid),
    .cont_key   (cont_key),
    .cont_joy   (cont_joy),
    .overrun_cnt(overrun_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  // ---------------------------------------------------------------- model
  logic        m_valid = 1'b0;
  logic [15:0] m_key   = 16'h0000;
  int          m_lx    = 128;
  int          m_ly    = 128;
  int          m_ovr   = 0;

  function automatic logic [3:0] tb_clean(input logic [3:0] d);
    logic [3:0] r;
    r = d;
    if (d[0] && d[1]) r = r & 4'b1100;
    if (d[2] && d[3]) r = r & 4'b0011;
    return r;
  endfunction

  function automatic int target(input logic neg, input logic pos);
    if (neg) return 0;
    if (pos) return 255;
    return 128;
  endfunction

`ifdef POCKET_PAD_SLEW_EN
  function automatic int move(input int cur, input int tgt);
    if (tgt > cur) return (cur + SLEW > tgt) ? tgt : cur + SLEW;
    if (tgt < cur) return (cur - SLEW < tgt) ? tgt : cur - SLEW;
    return cur;
  endfunction
`endif

  // Reference behaviour: accept when idle or when the handshake coincides.
  always @(posedge clk_sys or negedge reset_n) begin
    logic [3:0] d;
    int tx, ty;
    if (!reset_n) begin
      m_valid <= 1'b0;
      m_key   <= 16'h0000;
      m_lx    <= 128;
      m_ly    <= 128;
      m_ovr   <= 0;
    end else if (frame_stb && (!m_valid || word_ready)) begin
      d  = tb_clean(stick_dir);
      tx = target(d[2], d[3]);
      ty = target(d[0], d[1]);
      m_valid <= 1'b1;
      m_key   <= {key_in[15:4], tb_clean(key_in[3:0])};
`ifdef POCKET_PAD_SLEW_EN
      m_lx    <= move(m_lx, tx);
      m_ly    <= move(m_ly, ty);
`else
      m_lx    <= tx;
      m_ly    <= ty;
`endif
    end else if (frame_stb) begin
      if (m_ovr < 255) m_ovr <= m_ovr + 1;
    end else if (word_ready) begin
      m_valid <= 1'b0;
    end
  end

  logic [31:0] exp_key;
  logic [31:0] exp_joy;
  assign exp_key = {PAD, 13'h0000, m_key};
  assign exp_joy = {8'h80, 8'h80, 8'(m_ly), 8'(m_lx)};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk_sys) begin
    check("cyc word_valid", {31'h0, word_valid}, {31'h0, m_valid});
    check("cyc cont_key", cont_key, exp_key);
    check("cyc cont_joy", cont_joy, exp_joy);
    check("cyc overrun_cnt", {24'h0, overrun_cnt}, 32'(m_ovr));
  end

  // ---------------------------------------------------------------- stimulus
  task automatic strobe(input logic [15:0] k, input logic [3:0] d, input logic rdy);
    @(negedge clk_sys);
    frame_stb  = 1'b1;
    key_in     = k;
    stick_dir  = d;
    word_ready = rdy;
    @(negedge clk_sys);
    frame_stb  = 1'b0;
    word_ready = 1'b0;
  endtask

  task automatic ack();
    @(negedge clk_sys);
    word_ready = 1'b1;
    @(negedge clk_sys);
    word_ready = 1'b0;
  endtask

  task automatic check_joy(input string name, input logic [31:0] exp);
    check({"lit ", name}, cont_joy, exp);
    check({"model ", name}, exp_joy, exp);
  endtask

  initial begin
    logic [7:0] up_seq [5];
    logic [7:0] dn_seq [4];
    up_seq = '{8'hA0, 8'hC0, 8'hE0, 8'hFF, 8'hFF};
    dn_seq = '{8'hDF, 8'hBF, 8'h9F, 8'h80};

    // Reset state.
    repeat (3) @(negedge clk_sys);
    check("rst word_valid", {31'h0, word_valid}, 32'h0);
    check("rst cont_key", cont_key, 32'h2000_0000);
    check("rst cont_joy", cont_joy, 32'h8080_8080);
    check("rst overrun", {24'h0, overrun_cnt}, 32'h0);
    reset_n = 1'b1;

    // Reset and pack.
    strobe(16'h0011, 4'b0000, 1'b0);
    check("pack word_valid", {31'h0, word_valid}, 32'h1);
    check("pack cont_key", cont_key, 32'h2000_0011);
    check_joy("pack joy", 32'h8080_8080);
    ack();
    check("ack word_valid", {31'h0, word_valid}, 32'h0);

    // SOCD on keys.
    strobe(16'h000F, 4'b0000, 1'b0);
    check("socd key", cont_key, 32'h2000_0000);
    ack();
    strobe(16'h0106, 4'b0000, 1'b0);
    check("socd key partial", cont_key, 32'h2000_0106);
    ack();

`ifdef POCKET_PAD_SLEW_EN
    for (int i = 0; i < 5; i++) begin
      strobe(16'h0000, 4'b1000, 1'b0);
      check_joy("slew up", {24'h8080_80, up_seq[i]});
      ack();
    end
    for (int i = 0; i < 4; i++) begin
      strobe(16'h0000, 4'b0000, 1'b0);
      check_joy("slew back", {24'h8080_80, dn_seq[i]});
      ack();
    end
`else
    strobe(16'h0000, 4'b0001, 1'b0);
    check_joy("direct up", 32'h8080_0080);
    ack();
    strobe(16'h0000, 4'b1000, 1'b0);
    check_joy("direct right", 32'h8080_80FF);
    ack();
    strobe(16'h0000, 4'b0011, 1'b0);
    check_joy("direct socd", 32'h8080_8080);
    ack();
`endif

    // Overrun: 300 dropped strobes, then a strobe coinciding with the handshake.
    strobe(16'h1234, 4'b0000, 1'b0);
    @(negedge clk_sys);
    frame_stb = 1'b1;
    key_in    = 16'hFFFF;
    stick_dir = 4'b1000;
    repeat (300) @(negedge clk_sys);
    frame_stb = 1'b0;
    check("ovr cont_key held", cont_key, 32'h2000_1234);
    check_joy("ovr joy held", 32'h8080_8080);
    check("ovr saturated", {24'h0, overrun_cnt}, 32'h0000_00FF);
    check("ovr still valid", {31'h0, word_valid}, 32'h1);
    strobe(16'hABCD, 4'b0000, 1'b1);
    check("hs+stb cont_key", cont_key, 32'h2000_ABC1);
    check("hs+stb overrun", {24'h0, overrun_cnt}, 32'h0000_00FF);
    check("hs+stb valid", {31'h0, word_valid}, 32'h1);
    ack();

    // Reset mid-PEND, checked before the next clock edge.
    strobe(16'h0000, 4'b1000, 1'b0);
    ack();
    strobe(16'h0000, 4'b1000, 1'b0);
    ack();
    strobe(16'h0000, 4'b1000, 1'b0);
`ifdef POCKET_PAD_SLEW_EN
    check_joy("pre-reset joy", 32'h8080_80E0);
`else
    check_joy("pre-reset joy", 32'h8080_80FF);
`endif
    #2 reset_n = 1'b0;
    #1;
    check("async rst valid", {31'h0, word_valid}, 32'h0);
    check("async rst joy", cont_joy, 32'h8080_8080);
    check("async rst key", cont_key, 32'h2000_0000);
    check("async rst overrun", {24'h0, overrun_cnt}, 32'h0);
    @(negedge clk_sys);
    reset_n = 1'b1;
    strobe(16'h0001, 4'b0000, 1'b0);
    check("post-reset valid", {31'h0, word_valid}, 32'h1);
    check("post-reset key", cont_key, 32'h2000_0001);
    ack();

    // Randomized traffic with occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk_sys);
      frame_stb  = ($urandom_range(0, 2) == 0);
      word_ready = 1'($urandom_range(0, 1));
      key_in     = 16'($urandom);
      stick_dir  = 4'($urandom);
      if ((i % 700) == 350) begin
        #2 reset_n = 1'b0;
        @(negedge clk_sys);
        reset_n = 1'b1;
      end
    end
    @(negedge clk_sys);
    frame_stb  = 1'b0;
    word_ready = 1'b0;
    repeat (2) @(negedge clk_sys);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
